// File: rtl/uart_rx.sv
// uart_rx: receive half of the debug UART.
// Recovers 8N1-style frames (start 0, 8 data bits, >=1 stop bit 1) from an
// asynchronous serial line, sampling each bit at its midpoint on i_clk.
//
// Ports
//   i_clk          system clock
//   i_rst          asynchronous, active-high reset
//   i_uart_rx      serial line (idles high), asynchronous to i_clk
//   o_rx_data      last good byte, held until the next good frame
//   o_rx_valid     one-cycle pulse, o_rx_data valid in the same cycle
//   o_rx_frame_err one-cycle pulse when the stop bit samples low
//   o_rx_busy      high whenever the receiver is not idle
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | line idle, waiting for a low level on rx_s
// START     | counting to mid start bit to confirm it is not a glitch
// DATA      | sampling 8 data bits, one every BIT_CLKS cycles
// STOP      | sampling the stop bit; good -> valid, low -> frame error
// WAIT_HIGH | after a frame error, wait for the line to return high
module uart_rx #(
  parameter int CLOCK_FREQUENCY = 12_000_000,
  parameter int BAUD_RATE       = 115200,
  parameter bit MSB_FIRST       = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_uart_rx,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  output logic       o_rx_frame_err,
  output logic       o_rx_busy
);

  localparam int BIT_CLKS  = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int HALF_CLKS = BIT_CLKS / 2;
  localparam int CW        = $clog2(BIT_CLKS) + 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CLKS - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_CLKS - 1);

  if (BIT_CLKS < 4) begin : g_bad_cfg
    $error("uart_rx: CLOCK_FREQUENCY/BAUD_RATE must be at least 4");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;
  logic          busy_q, busy_d;
  logic          rx_s;

  assign rx_s = sync_q[1];

  always_comb begin
    sync_d  = {sync_q[0], i_uart_rx};
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          idx_d = '0;
          // A high level at mid start bit means it was a glitch: drop it silently.
          state_d = rx_s ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (MSB_FIRST) shift_d = {shift_q[6:0], rx_s};
          else           shift_d = {rx_s, shift_q[7:1]};
          if (idx_q == 3'd7) state_d = S_STOP;
          else               idx_d   = idx_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = S_WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT_HIGH: begin
        // Holding here on a low line keeps a break from looking like new starts.
        cnt_d = '0;
        if (rx_s) state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync_q  <= 2'b11;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign o_rx_data      = data_q;
  assign o_rx_valid     = valid_q;
  assign o_rx_frame_err = err_q;
  assign o_rx_busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_pin = 1'b1;
  logic [7:0] rx_data, l_data;
  logic       rx_valid, rx_err, rx_busy;
  logic       l_valid, l_err, l_busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int frame_start = 0;
  int both_cnt = 0;
  logic busy_prev = 1'b0;

  logic [7:0] vq_data[$];
  int         vq_cyc[$];
  logic       vq_busy[$];
  logic       vq_busy_prev[$];
  int         eq_cyc[$];
  logic [7:0] lq_data[$];

  uart_rx #(.CLOCK_FREQUENCY(12_000_000), .BAUD_RATE(1_000_000), .MSB_FIRST(1'b1)) dut (
    .i_clk(clk), .i_rst(rst), .i_uart_rx(rx_pin),
    .o_rx_data(rx_data), .o_rx_valid(rx_valid),
    .o_rx_frame_err(rx_err), .o_rx_busy(rx_busy)
  );

  uart_rx #(.CLOCK_FREQUENCY(12_000_000), .BAUD_RATE(1_000_000), .MSB_FIRST(1'b0)) dut_lsb (
    .i_clk(clk), .i_rst(rst), .i_uart_rx(rx_pin),
    .o_rx_data(l_data), .o_rx_valid(l_valid),
    .o_rx_frame_err(l_err), .o_rx_busy(l_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid) begin
      vq_data.push_back(rx_data);
      vq_cyc.push_back(cyc);
      vq_busy.push_back(rx_busy);
      vq_busy_prev.push_back(busy_prev);
    end
    if (rx_err) eq_cyc.push_back(cyc);
    if (rx_valid && rx_err) both_cnt <= both_cnt + 1;
    if (l_valid) lq_data.push_back(l_data);
    busy_prev <= rx_busy;
  end

  task automatic clear_q();
    vq_data.delete(); vq_cyc.delete(); vq_busy.delete(); vq_busy_prev.delete();
    eq_cyc.delete(); lq_data.delete();
  endtask

  task automatic align();
    @(posedge clk); #1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one frame starting now; a low stop bit leaves the line low on return.
  task automatic send_frame(input logic [7:0] b, input bit msb, input bit stop_val,
                            input int stop_bits, input int bit_ns);
    frame_start = cyc;
    rx_pin = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      rx_pin = msb ? b[7-i] : b[i];
      #(bit_ns);
    end
    rx_pin = stop_val;
    #(bit_ns);
    if (stop_val) #(bit_ns * (stop_bits - 1));
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_pin = 1'b1;
    wait_cycles(3);
    @(negedge clk);
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %0h expected 00", rx_data); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", rx_valid); end
    checks++; if (rx_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b expected 0", rx_err); end
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", rx_busy); end
    align();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy[%0d]: got %0b expected 0", i, rx_busy); end
    end
    wait_cycles(5);
  endtask

  task automatic test_single_byte();
    int s;
    clear_q();
    align();
    s = cyc;
    send_frame(8'hA5, 1'b1, 1'b1, 3, 120);
    wait_cycles(20);
    checks++;
    if (vq_data.size() != 1) begin
      errors++; $display("FAIL single_count: got %0d pulses expected 1", vq_data.size());
    end else begin
      checks++; if (vq_data[0] !== 8'hA5) begin errors++; $display("FAIL single_data: got %0h expected a5", vq_data[0]); end
      checks++; if (vq_cyc[0] != s + 117) begin errors++; $display("FAIL single_latency: got cycle %0d expected %0d", vq_cyc[0], s + 117); end
      checks++; if (vq_busy[0] !== 1'b0) begin errors++; $display("FAIL single_busy_fall: got %0b expected 0", vq_busy[0]); end
      checks++; if (vq_busy_prev[0] !== 1'b1) begin errors++; $display("FAIL single_busy_before: got %0b expected 1", vq_busy_prev[0]); end
    end
    checks++; if (eq_cyc.size() != 0) begin errors++; $display("FAIL single_no_err: got %0d errors expected 0", eq_cyc.size()); end
  endtask

  task automatic test_back_to_back();
    int s;
    logic [7:0] exp_b [3];
    exp_b = '{8'h00, 8'hFF, 8'h3C};
    clear_q();
    align();
    s = cyc;
    send_frame(8'h00, 1'b1, 1'b1, 1, 120);
    send_frame(8'hFF, 1'b1, 1'b1, 1, 120);
    send_frame(8'h3C, 1'b1, 1'b1, 1, 120);
    wait_cycles(20);
    checks++;
    if (vq_data.size() != 3) begin
      errors++; $display("FAIL b2b_count: got %0d pulses expected 3", vq_data.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++; if (vq_data[i] !== exp_b[i]) begin errors++; $display("FAIL b2b_data[%0d]: got %0h expected %0h", i, vq_data[i], exp_b[i]); end
        checks++; if (vq_cyc[i] != s + 117 + 120 * i) begin errors++; $display("FAIL b2b_cycle[%0d]: got %0d expected %0d", i, vq_cyc[i], s + 117 + 120 * i); end
      end
    end
    checks++; if (eq_cyc.size() != 0) begin errors++; $display("FAIL b2b_no_err: got %0d errors expected 0", eq_cyc.size()); end
  endtask

  task automatic test_glitch();
    int s;
    clear_q();
    align();
    s = cyc;
    rx_pin = 1'b0;
    wait_cycles(3);
    rx_pin = 1'b1;
    wait_cycles(5);
    @(negedge clk);
    checks++; if (rx_busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_at_sample: got %0b expected 1", rx_busy); end
    align();
    @(negedge clk);
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL glitch_back_idle: got %0b expected 0", rx_busy); end
    wait_cycles(20);
    checks++; if (vq_data.size() != 0) begin errors++; $display("FAIL glitch_no_valid: got %0d pulses expected 0", vq_data.size()); end
    checks++; if (eq_cyc.size() != 0) begin errors++; $display("FAIL glitch_no_err: got %0d errors expected 0", eq_cyc.size()); end
    checks++; if (rx_data !== 8'h3C) begin errors++; $display("FAIL glitch_data_held: got %0h expected 3c", rx_data); end
  endtask

  task automatic test_frame_err();
    int s;
    clear_q();
    align();
    s = cyc;
    send_frame(8'h55, 1'b1, 1'b0, 1, 120);
    wait_cycles(50);
    @(negedge clk);
    checks++; if (rx_busy !== 1'b1) begin errors++; $display("FAIL ferr_busy_held: got %0b expected 1", rx_busy); end
    align();
    rx_pin = 1'b1;
    wait_cycles(5);
    @(negedge clk);
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL ferr_busy_release: got %0b expected 0", rx_busy); end
    checks++;
    if (eq_cyc.size() != 1) begin
      errors++; $display("FAIL ferr_count: got %0d pulses expected 1", eq_cyc.size());
    end else begin
      checks++; if (eq_cyc[0] != s + 117) begin errors++; $display("FAIL ferr_cycle: got %0d expected %0d", eq_cyc[0], s + 117); end
    end
    checks++; if (vq_data.size() != 0) begin errors++; $display("FAIL ferr_no_valid: got %0d pulses expected 0", vq_data.size()); end
    checks++; if (rx_data !== 8'h3C) begin errors++; $display("FAIL ferr_data_held: got %0h expected 3c", rx_data); end
    clear_q();
    align();
    send_frame(8'h81, 1'b1, 1'b1, 1, 120);
    wait_cycles(20);
    checks++;
    if (vq_data.size() != 1) begin
      errors++; $display("FAIL ferr_recover_count: got %0d pulses expected 1", vq_data.size());
    end else begin
      checks++; if (vq_data[0] !== 8'h81) begin errors++; $display("FAIL ferr_recover_data: got %0h expected 81", vq_data[0]); end
    end
    checks++; if (both_cnt != 0) begin errors++; $display("FAIL valid_and_err_together: got %0d expected 0", both_cnt); end
  endtask

  task automatic test_reset_mid_frame();
    clear_q();
    align();
    fork
      send_frame(8'h5A, 1'b1, 1'b1, 3, 120);
      begin
        wait_cycles(66);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL midrst_data: got %0h expected 00", rx_data); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %0b expected 0", rx_valid); end
        checks++; if (rx_err !== 1'b0) begin errors++; $display("FAIL midrst_err: got %0b expected 0", rx_err); end
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %0b expected 0", rx_busy); end
        wait_cycles(84);
        rst = 1'b0;
      end
    join
    wait_cycles(10);
    checks++; if (vq_data.size() != 0) begin errors++; $display("FAIL midrst_no_pulse: got %0d pulses expected 0", vq_data.size()); end
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL midrst_idle_after: got %0b expected 0", rx_busy); end
    clear_q();
    align();
    send_frame(8'hC3, 1'b1, 1'b1, 1, 120);
    wait_cycles(20);
    checks++;
    if (vq_data.size() != 1) begin
      errors++; $display("FAIL midrst_next_count: got %0d pulses expected 1", vq_data.size());
    end else begin
      checks++; if (vq_data[0] !== 8'hC3) begin errors++; $display("FAIL midrst_next_data: got %0h expected c3", vq_data[0]); end
    end
  endtask

  task automatic test_lsb_first();
    int bit_ns [3];
    bit_ns = '{120, 124, 116};
    for (int k = 0; k < 3; k++) begin
      clear_q();
      align();
      send_frame(8'h12, 1'b0, 1'b1, 1, bit_ns[k]);
      wait_cycles(30);
      checks++;
      if (lq_data.size() != 1) begin
        errors++; $display("FAIL lsb_count[%0dns]: got %0d pulses expected 1", bit_ns[k], lq_data.size());
      end else begin
        checks++; if (lq_data[0] !== 8'h12) begin errors++; $display("FAIL lsb_data[%0dns]: got %0h expected 12", bit_ns[k], lq_data[0]); end
      end
      if (k == 0) begin
        // The MSB-first receiver sees the same wire bits in reverse order.
        checks++;
        if (vq_data.size() != 1) begin
          errors++; $display("FAIL msb_view_count: got %0d pulses expected 1", vq_data.size());
        end else begin
          checks++; if (vq_data[0] !== 8'h48) begin errors++; $display("FAIL msb_view_data: got %0h expected 48", vq_data[0]); end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_mid_frame();
    test_lsb_first();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
